// File: rtl/reg_trace_buf.sv
// Shadow GPR file plus a sequenced write-trace ring buffer drained over a valid/ready port.
// Every architectural write gets a sequence number; writes that do not fit are dropped but still consume one.
module reg_trace_buf #(
   parameter  int DATA_WIDTH = 32,
   parameter  int ADDR_WIDTH = 5,
   parameter  int NUM_WPORTS = 2,
   parameter  int DEPTH      = 16,
   parameter  int SEQ_WIDTH  = 16,
   parameter  int ZERO_REG   = 1,
   localparam int PW         = (NUM_WPORTS > 1) ? $clog2(NUM_WPORTS) : 1,
   localparam int CW         = $clog2(DEPTH) + 1
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [NUM_WPORTS-1:0]                 wen,
   input  logic [NUM_WPORTS*ADDR_WIDTH-1:0]      waddr,
   input  logic [NUM_WPORTS*DATA_WIDTH-1:0]      wdata,
   output logic [(1<<ADDR_WIDTH)*DATA_WIDTH-1:0] regfile,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [ADDR_WIDTH-1:0]                 out_addr,
   output logic [DATA_WIDTH-1:0]                 out_data,
   output logic [PW-1:0]                         out_port,
   output logic [SEQ_WIDTH-1:0]                  out_seq,
   output logic [CW-1:0]                         count,
   output logic                                  overflow,
   input  logic                                  clr_ovf
);

   localparam int            NREGS   = 1 << ADDR_WIDTH;
   localparam int            AW      = $clog2(DEPTH);
   localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
      logic [PW-1:0]         port;
      logic [SEQ_WIDTH-1:0]  seq;
   } entry_t;

   logic [DATA_WIDTH-1:0] regfile_q [NREGS];
   logic [DATA_WIDTH-1:0] regfile_d [NREGS];
   entry_t                mem_q     [DEPTH];
   entry_t                mem_d     [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
   logic                  ovf_q, ovf_d;

   logic                  pop;
   logic [CW:0]           free;
   logic [CW:0]           pushed;
   logic                  drop;

   // Handshake: the head entry is transferred on a cycle where out_valid and
   // out_ready are both high; while out_valid=1 and out_ready=0 the out_* payload holds.
   assign out_valid = (count_q != '0);
   assign out_addr  = mem_q[rd_ptr_q].addr;
   assign out_data  = mem_q[rd_ptr_q].data;
   assign out_port  = mem_q[rd_ptr_q].port;
   assign out_seq   = mem_q[rd_ptr_q].seq;
   assign count     = count_q;
   assign overflow  = ovf_q;

   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         regfile[i*DATA_WIDTH +: DATA_WIDTH] = regfile_q[i];
      end
   end

   always_comb begin
      pop       = out_valid & out_ready;
      free      = DEPTH_W - {1'b0, count_q} + {{CW{1'b0}}, pop};
      pushed    = '0;
      drop      = 1'b0;
      seq_d     = seq_q;
      mem_d     = mem_q;
      regfile_d = regfile_q;
      // Ascending port order gives both the seq ordering and highest-port-wins on the shadow file.
      for (int p = 0; p < NUM_WPORTS; p++) begin
         if (wen[p] && (ZERO_REG == 0 || waddr[p*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
            regfile_d[waddr[p*ADDR_WIDTH +: ADDR_WIDTH]] = wdata[p*DATA_WIDTH +: DATA_WIDTH];
            if (pushed < free) begin
               mem_d[wr_ptr_q + pushed[AW-1:0]] = '{addr: waddr[p*ADDR_WIDTH +: ADDR_WIDTH],
                                                    data: wdata[p*DATA_WIDTH +: DATA_WIDTH],
                                                    port: PW'(p),
                                                    seq:  seq_d};
               pushed = pushed + (CW+1)'(1);
            end else begin
               drop = 1'b1;
            end
            seq_d = seq_d + SEQ_WIDTH'(1);
         end
      end
      wr_ptr_d = wr_ptr_q + pushed[AW-1:0];
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + pushed[CW-1:0] - CW'(pop);
      // A drop in the same cycle as a clear leaves the flag set.
      ovf_d    = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regfile_q <= '{default: '0};
         mem_q     <= '{default: '0};
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         seq_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         regfile_q <= regfile_d;
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         seq_q     <= seq_d;
         ovf_q     <= ovf_d;
      end
   end

endmodule

// File: tb/tb_reg_trace_buf.sv
// Randomized bench for reg_trace_buf against a queue-based reference model of the trace buffer.
module tb_reg_trace_buf;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NP    = 2;
   localparam int DEPTH = 16;
   localparam int SW    = 16;
   localparam int NR    = 1 << AW;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NP-1:0]      wen = '0;
   logic [NP*AW-1:0]   waddr = '0;
   logic [NP*DW-1:0]   wdata = '0;
   logic [NR*DW-1:0]   regfile;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [AW-1:0]      out_addr;
   logic [DW-1:0]      out_data;
   logic [0:0]         out_port;
   logic [SW-1:0]      out_seq;
   logic [4:0]         count;
   logic               overflow;
   logic               clr_ovf = 1'b0;

   always #5 clk = ~clk;

   reg_trace_buf #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WPORTS(NP), .DEPTH(DEPTH),
                   .SEQ_WIDTH(SW), .ZERO_REG(1)) dut (
      .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
      .regfile(regfile), .out_valid(out_valid), .out_ready(out_ready),
      .out_addr(out_addr), .out_data(out_data), .out_port(out_port), .out_seq(out_seq),
      .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: shadow array, queue of packed {addr,data,port,seq}, seq counter, sticky flag.
   logic [DW-1:0] m_rf [NR];
   logic [63:0]   m_q [$];
   logic [SW-1:0] m_seq;
   logic          m_ovf;

   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_rf[i] = '0;
      m_q.delete();
      m_seq = '0;
      m_ovf = 1'b0;
   endtask

   task automatic check_all();
      check("count", 64'(count), 64'(m_q.size()));
      check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
      check("overflow", 64'(overflow), 64'(m_ovf));
      if (m_q.size() != 0) check("head", 64'({out_addr, out_data, out_port, out_seq}), m_q[0]);
      for (int i = 0; i < NR; i++) check("regfile", 64'(regfile[i*DW +: DW]), 64'(m_rf[i]));
   endtask

   task automatic do_reset();
      rst_n = 1'b0; wen = '0; out_ready = 1'b0; clr_ovf = 1'b0;
      #2;
      model_reset();
      check_all();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic cycle(input logic [NP-1:0] w, input logic [NP*AW-1:0] a,
                        input logic [NP*DW-1:0] d, input logic rdy, input logic clr);
      logic drop;
      wen = w; waddr = a; wdata = d; out_ready = rdy; clr_ovf = clr;
      if (rdy && m_q.size() != 0) void'(m_q.pop_front());
      drop = 1'b0;
      for (int p = 0; p < NP; p++) begin
         if (w[p] && a[p*AW +: AW] != '0) begin
            m_rf[a[p*AW +: AW]] = d[p*DW +: DW];
            if (m_q.size() < DEPTH) m_q.push_back(64'({a[p*AW +: AW], d[p*DW +: DW], 1'(p), m_seq}));
            else drop = 1'b1;
            m_seq = m_seq + 1'b1;
         end
      end
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      @(posedge clk); #1;
      check_all();
   endtask

   task automatic single_write(input int port, input logic rdy);
      logic [NP*AW-1:0] a;
      logic [NP*DW-1:0] d;
      logic [NP-1:0]    w;
      a = '0; w = '0;
      d = {$urandom, $urandom};
      a[port*AW +: AW] = AW'($urandom_range(1, NR-1));
      w[port] = 1'b1;
      cycle(w, a, d, rdy, 1'b0);
   endtask

   initial begin
      logic [SW-1:0] prev_seq;
      logic          seen_wrap;

      do_reset();

      cycle(2'b01, {5'd0, 5'd3}, {32'd0, 32'hDEADBEEF}, 1'b0, 1'b0);
      check("t1_data", 64'(out_data), 64'h0000_0000_DEAD_BEEF);
      check("t1_seq", 64'(out_seq), 64'd0);
      check("t1_rf3", 64'(regfile[3*DW +: DW]), 64'hDEAD_BEEF);

      cycle(2'b11, {5'd5, 5'd5}, {32'h22, 32'h11}, 1'b0, 1'b0);
      check("t2_rf5", 64'(regfile[5*DW +: DW]), 64'h22);
      check("t2_count", 64'(count), 64'd3);

      cycle(2'b01, {5'd0, 5'd0}, {32'd0, 32'h55}, 1'b0, 1'b0);
      check("t3_rf0", 64'(regfile[0 +: DW]), 64'd0);
      check("t3_count", 64'(count), 64'd3);
      for (int i = 0; i < 3; i++) cycle('0, '0, '0, 1'b1, 1'b0);
      single_write(0, 1'b0);
      check("t3_seq", 64'(out_seq), 64'd3);

      do_reset();
      for (int i = 0; i < 15; i++) single_write(int'($urandom_range(0, 1)), 1'b0);
      cycle(2'b11, {5'd7, 5'd9}, {32'hAAAA_0001, 32'hBBBB_0002}, 1'b0, 1'b0);
      check("t4_count", 64'(count), 64'd16);
      check("t4_ovf", 64'(overflow), 64'd1);
      cycle('0, '0, '0, 1'b0, 1'b1);
      check("t4_clr", 64'(overflow), 64'd0);
      cycle(2'b10, {5'd11, 5'd0}, {32'hCAFE_F00D, 32'd0}, 1'b1, 1'b0);
      check("t5_count", 64'(count), 64'd16);
      check("t5_ovf", 64'(overflow), 64'd0);
      for (int i = 0; i < 18; i++) cycle('0, '0, '0, 1'b1, 1'b0);
      check("t5_drained", 64'(count), 64'd0);

      do_reset();
      prev_seq = '0; seen_wrap = 1'b0;
      for (int i = 0; i < 70000; i++) begin
         if (i == 68000) do_reset();
         single_write(int'($urandom_range(0, 1)), 1'b1);
         if (out_valid) begin
            if (prev_seq == 16'hFFFF && out_seq == 16'h0000) seen_wrap = 1'b1;
            prev_seq = out_seq;
         end
      end
      check("t6_wrap", 64'(seen_wrap), 64'd1);
      check("t6_nodrop", 64'(overflow), 64'd0);
      check("t6_seq_after_reset", 64'(out_seq), 64'd1999);

      for (int i = 0; i < 3000; i++) begin
         cycle(NP'($urandom), NP*AW'($urandom), {$urandom, $urandom},
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 15) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
